// File: rtl/interrupt_sequencer.sv
// Interrupt sequencer for the multi-cycle MIPS core: arbitrates INT/NMI at
// instruction boundaries, supports one level of NMI-over-INT nesting.
module interrupt_sequencer #(
   parameter int unsigned     PC_W    = 32,
   parameter logic [PC_W-1:0] VEC_INT = PC_W'(32'h0000_0080),
   parameter logic [PC_W-1:0] VEC_NMI = PC_W'(32'h0000_0040)
) (
   input  logic            clk,
   input  logic            reset,
   input  logic            INT,
   input  logic            NMI,
   input  logic            INTD,
   input  logic            instr_done,
   input  logic            eret,
   input  logic [PC_W-1:0] pc_in,
   output logic            isInterrupted,
   output logic            INA,
   output logic [PC_W-1:0] epc,
   output logic [PC_W-1:0] vector,
   output logic [1:0]      cause,
   output logic            in_service
);

   localparam logic [1:0] CAUSE_NONE = 2'b00;
   localparam logic [1:0] CAUSE_INT  = 2'b01;
   localparam logic [1:0] CAUSE_NMI  = 2'b10;

   typedef enum logic [2:0] {
      IDLE,
      ACK_INT,
      ACK_NMI,
      SRV_INT,
      SRV_NMI,
      SRV_NEST
   } state_t;

   state_t          state, state_n;
   logic            nest, nest_n;
   logic            nmi_prev, nmi_pend, nmi_pend_n;
   logic [PC_W-1:0] epc_int, epc_int_n;
   logic [PC_W-1:0] epc_nmi, epc_nmi_n;
   logic            take_nmi;
   logic            ack_n;
   logic [PC_W-1:0] epc_n, vector_n;
   logic [1:0]      cause_n;
   logic            in_service_n;

   // Next state, captured return addresses and the outputs of the state being entered
   always_comb begin
      state_n   = state;
      nest_n    = nest;
      epc_int_n = epc_int;
      epc_nmi_n = epc_nmi;
      take_nmi  = 1'b0;

      case (state)
         IDLE: begin
            if (instr_done) begin
               if (nmi_pend) begin
                  state_n   = ACK_NMI;
                  nest_n    = 1'b0;
                  epc_nmi_n = pc_in;
                  take_nmi  = 1'b1;
               end else if (INT && !INTD) begin
                  state_n   = ACK_INT;
                  epc_int_n = pc_in;
               end
            end
         end
         ACK_INT: state_n = SRV_INT;
         ACK_NMI: state_n = nest ? SRV_NEST : SRV_NMI;
         SRV_INT: begin
            // eret has priority over a boundary in the same cycle
            if (eret) begin
               state_n = IDLE;
            end else if (instr_done && nmi_pend) begin
               state_n   = ACK_NMI;
               nest_n    = 1'b1;
               epc_nmi_n = pc_in;
               take_nmi  = 1'b1;
            end
         end
         SRV_NMI: begin
            if (eret) begin
               state_n = IDLE;
               nest_n  = 1'b0;
            end
         end
         SRV_NEST: begin
            if (eret) begin
               state_n = SRV_INT;
               nest_n  = 1'b0;
            end
         end
         default: state_n = IDLE;
      endcase

      // an edge coinciding with acceptance is absorbed by it
      nmi_pend_n = take_nmi ? 1'b0 : (nmi_pend | (NMI & ~nmi_prev));

      ack_n        = (state_n == ACK_INT) || (state_n == ACK_NMI);
      in_service_n = (state_n == SRV_INT) || (state_n == SRV_NMI) ||
                     (state_n == SRV_NEST) || ((state_n == ACK_NMI) && nest_n);

      cause_n  = CAUSE_NONE;
      epc_n    = epc;
      vector_n = vector;
      case (state_n)
         ACK_INT: begin
            cause_n  = CAUSE_INT;
            epc_n    = epc_int_n;
            vector_n = VEC_INT;
         end
         SRV_INT: begin
            cause_n = CAUSE_INT;
            epc_n   = epc_int_n;
         end
         ACK_NMI: begin
            cause_n  = CAUSE_NMI;
            epc_n    = epc_nmi_n;
            vector_n = VEC_NMI;
         end
         SRV_NMI, SRV_NEST: begin
            cause_n = CAUSE_NMI;
            epc_n   = epc_nmi_n;
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state         <= IDLE;
         nest          <= 1'b0;
         nmi_prev      <= 1'b0;
         nmi_pend      <= 1'b0;
         epc_int       <= '0;
         epc_nmi       <= '0;
         isInterrupted <= 1'b0;
         INA           <= 1'b0;
         epc           <= '0;
         vector        <= '0;
         cause         <= CAUSE_NONE;
         in_service    <= 1'b0;
      end else begin
         state         <= state_n;
         nest          <= nest_n;
         nmi_prev      <= NMI;
         nmi_pend      <= nmi_pend_n;
         epc_int       <= epc_int_n;
         epc_nmi       <= epc_nmi_n;
         isInterrupted <= ack_n;
         INA           <= ack_n;
         epc           <= epc_n;
         vector        <= vector_n;
         cause         <= cause_n;
         in_service    <= in_service_n;
      end
   end

endmodule

// File: tb/tb_interrupt_sequencer.sv
// Directed bench for interrupt_sequencer: a handler-stack model checked every
// cycle, plus hand-computed literal expectations at key points.
module tb_interrupt_sequencer;

   localparam int unsigned PC_W = 32;
   localparam logic [31:0] V_INT = 32'h0000_0080;
   localparam logic [31:0] V_NMI = 32'h0000_0040;

   logic            clk = 1'b0;
   logic            reset = 1'b1;
   logic            INT = 1'b0, NMI = 1'b0, INTD = 1'b0;
   logic            instr_done = 1'b0, eret = 1'b0;
   logic [PC_W-1:0] pc_in = '0;
   logic            isInterrupted, INA, in_service;
   logic [PC_W-1:0] epc, vector;
   logic [1:0]      cause;

   int checks = 0;
   int errors = 0;
   bit chk_en = 1'b0;

   interrupt_sequencer #(.PC_W(PC_W)) dut (
      .clk(clk), .reset(reset), .INT(INT), .NMI(NMI), .INTD(INTD),
      .instr_done(instr_done), .eret(eret), .pc_in(pc_in),
      .isInterrupted(isInterrupted), .INA(INA), .epc(epc), .vector(vector),
      .cause(cause), .in_service(in_service)
   );

   always #5 clk = ~clk;

   // Model: a stack of active handlers (type 1=INT, 2=NMI, with return PC)
   int          stk_type[$];
   logic [31:0] stk_epc[$];
   int          m_ack = 0;
   bit          m_pend = 1'b0, m_prev = 1'b0;
   logic [31:0] m_vec = '0, m_epc = '0;

   always @(posedge clk or posedge reset) begin
      bit edge_seen, took;
      if (reset) begin
         stk_type.delete(); stk_epc.delete();
         m_ack = 0; m_pend = 1'b0; m_prev = 1'b0; m_vec = '0; m_epc = '0;
      end else begin
         edge_seen = NMI && !m_prev;
         m_prev    = NMI;
         took      = 1'b0;
         if (m_ack != 0) begin
            m_ack = 0;
         end else if (eret && stk_type.size() > 0) begin
            void'(stk_type.pop_back()); void'(stk_epc.pop_back());
         end else if (instr_done) begin
            if (stk_type.size() == 0 && m_pend) begin
               took = 1'b1;
            end else if (stk_type.size() == 0 && INT && !INTD) begin
               stk_type.push_back(1); stk_epc.push_back(pc_in);
               m_ack = 1; m_vec = V_INT;
            end else if (stk_type.size() == 1 && stk_type[0] == 1 && m_pend) begin
               took = 1'b1;
            end
            if (took) begin
               stk_type.push_back(2); stk_epc.push_back(pc_in);
               m_ack = 2; m_vec = V_NMI;
            end
         end
         m_pend = took ? 1'b0 : (m_pend | edge_seen);
         if (stk_type.size() > 0) m_epc = stk_epc[stk_epc.size()-1];
      end
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
      end
   endtask

   // Every-cycle comparison against the model
   always @(negedge clk) begin
      if (chk_en) begin
         int          n;
         logic [1:0]  e_cause;
         bit          e_srv;
         n       = stk_type.size();
         e_cause = (n > 0) ? 2'(stk_type[n-1]) : 2'b00;
         e_srv   = (n > 1) || (n == 1 && m_ack == 0);
         check("isInterrupted", 32'(isInterrupted), 32'(m_ack != 0));
         check("INA", 32'(INA), 32'(m_ack != 0));
         check("cause", 32'(cause), 32'(e_cause));
         check("in_service", 32'(in_service), 32'(e_srv));
         check("vector", vector, m_vec);
         check("epc", epc, m_epc);
      end
   end

   task automatic cyc();
      @(posedge clk); #1;
   endtask

   task automatic boundary(input logic [31:0] pc);
      instr_done = 1'b1; pc_in = pc;
      cyc();
      instr_done = 1'b0;
   endtask

   task automatic do_eret();
      eret = 1'b1;
      cyc();
      eret = 1'b0;
   endtask

   initial begin
      repeat (2) cyc();
      check("rst_ina", 32'(INA), 32'd0);
      check("rst_cause", 32'(cause), 32'd0);
      check("rst_epc", epc, 32'd0);
      reset = 1'b0;
      chk_en = 1'b1;

      // Basic INT acceptance
      INT = 1'b1;
      repeat (3) cyc();
      boundary(32'h124);
      check("t1_ina", 32'(INA), 32'd1);
      check("t1_isint", 32'(isInterrupted), 32'd1);
      check("t1_vector", vector, 32'h80);
      check("t1_cause", 32'(cause), 32'd1);
      check("t1_insvc_ack", 32'(in_service), 32'd0);
      INT = 1'b0;
      cyc();
      check("t1_epc", epc, 32'h124);
      check("t1_insvc", 32'(in_service), 32'd1);
      check("t1_ina_drop", 32'(INA), 32'd0);
      do_eret();
      check("t1_cause_idle", 32'(cause), 32'd0);
      check("t1_epc_hold", epc, 32'h124);

      // INTD masks INT across many boundaries
      INT = 1'b1; INTD = 1'b1;
      for (int i = 0; i < 10; i++) begin
         boundary(32'h140 + 32'(i));
         check("t2_masked", 32'(INA), 32'd0);
         cyc();
      end
      INTD = 1'b0;
      boundary(32'h150);
      check("t2_unmasked", 32'(INA), 32'd1);
      INT = 1'b0;
      cyc();
      do_eret();

      // NMI beats INT; held-high NMI does not re-trigger
      NMI = 1'b1; INT = 1'b1;
      cyc();
      boundary(32'h200);
      check("t3_vector", vector, 32'h40);
      check("t3_cause", 32'(cause), 32'd2);
      check("t3_epc", epc, 32'h200);
      cyc();
      do_eret();
      boundary(32'h204);
      check("t3_int_cause", 32'(cause), 32'd1);
      check("t3_int_vector", vector, 32'h80);
      INT = 1'b0; NMI = 1'b0;
      cyc();
      do_eret();

      // NMI nested on INT
      INT = 1'b1;
      boundary(32'h300);
      INT = 1'b0;
      cyc();
      NMI = 1'b1; cyc(); NMI = 1'b0;
      boundary(32'h88);
      check("t4_ina", 32'(INA), 32'd1);
      check("t4_cause", 32'(cause), 32'd2);
      check("t4_epc_ack", epc, 32'h88);
      cyc();
      check("t4_epc_nest", epc, 32'h88);
      check("t4_insvc", 32'(in_service), 32'd1);
      do_eret();
      check("t4_epc_back", epc, 32'h300);
      check("t4_cause_back", 32'(cause), 32'd1);
      do_eret();
      check("t4_idle", 32'(cause), 32'd0);

      // eret with instr_done: eret wins, NMI taken at the next boundary
      INT = 1'b1;
      boundary(32'h400);
      INT = 1'b0;
      cyc();
      NMI = 1'b1; cyc(); NMI = 1'b0; cyc();
      eret = 1'b1; instr_done = 1'b1; pc_in = 32'h500;
      cyc();
      eret = 1'b0; instr_done = 1'b0;
      check("t5_no_ack", 32'(INA), 32'd0);
      check("t5_idle", 32'(in_service), 32'd0);
      cyc();
      boundary(32'h504);
      check("t5_nmi_ina", 32'(INA), 32'd1);
      check("t5_nmi_vec", vector, 32'h40);
      check("t5_nmi_epc", epc, 32'h504);
      cyc();
      do_eret();

      // Async reset during ACK_NMI drops the acknowledge and loses the pending NMI
      NMI = 1'b1; cyc(); NMI = 1'b0; cyc();
      boundary(32'h600);
      check("t6_ina_pre", 32'(INA), 32'd1);
      #1 reset = 1'b1;
      #1;
      check("t6_ina_async", 32'(INA), 32'd0);
      check("t6_isint_async", 32'(isInterrupted), 32'd0);
      cyc();
      reset = 1'b0;
      cyc();
      check("t6_cause", 32'(cause), 32'd0);
      boundary(32'h700);
      check("t6_nmi_lost", 32'(INA), 32'd0);
      repeat (2) cyc();

      chk_en = 1'b0;
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
